// File: rtl/prog_sequencer_if.sv
// Control/address bundle between the decoder/flag logic and the program
// counter sequencer.
//   en            advance enable (0 = stall)
//   branch        take relative branch by offset
//   jump          absolute jump to target
//   call          push pc+1, then jump to target
//   ret           pop return address into pc
//   target        absolute destination for jump/call
//   offset        two's-complement displacement for branch
//   pc            current fetch address (drives program memory)
//   sp            number of valid return-stack entries
//   fault         sticky stack-error flag
// master: decoder side; slave: sequencer side.
interface prog_sequencer_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic                  en;
  logic                  branch;
  logic                  jump;
  logic                  call;
  logic                  ret;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] pc;
  logic [SP_W-1:0]       sp;
  logic                  fault;

  modport master (
    output en, branch, jump, call, ret, target, offset,
    input  pc, sp, fault
  );

  modport slave (
    input  en, branch, jump, call, ret, target, offset,
    output pc, sp, fault
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program-counter sequencer with a hardware return-address stack.
// Each enabled cycle performs exactly one of ret > call > jump > branch >
// increment. Stack overflow/underflow halts the sequencer until reset.
// Ports:
//   clk    system clock, rising-edge
//   reset  asynchronous active-high reset (pc=0, sp=0, fault=0)
//   bus    prog_sequencer_if.slave: controls in, pc/sp/fault out
module prog_sequencer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  prog_sequencer_if.slave  bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]       sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                  push;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      pop_idx;

  assign pc_inc   = pc_q + ADDR_WIDTH'(1);
  assign push_idx = IDX_W'(sp_q);
  // Only consulted when sp_q > 0, so it never points past the top entry.
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  // State register: control only; stack data carries no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  // Next-state selection. A failed stack check moves to HALT and leaves
  // pc/sp untouched; in HALT everything stays frozen.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push    = 1'b0;
    if (state_q == RUN && bus.en) begin
      if (bus.ret) begin
        if (sp_q == '0) begin
          state_d = HALT;
        end else begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_q - SP_W'(1);
        end
      end else if (bus.call) begin
        if (sp_q == SP_MAX) begin
          state_d = HALT;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
          pc_d = bus.target;
        end
      end else if (bus.jump) begin
        pc_d = bus.target;
      end else if (bus.branch) begin
        // Same-width add is the sign-extended displacement modulo 2^W.
        pc_d = pc_q + bus.offset;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  assign bus.pc    = pc_q;
  assign bus.sp    = sp_q;
  assign bus.fault = (state_q == HALT);
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Program-counter sequencer that drives the address input of the combinational program memory.
- Generates the next fetch address from sequential increment, relative branch, absolute jump, subroutine call and return.
- Holds return addresses in an internal hardware stack of configurable depth.
- Sits between the decoder/ALU flag logic and program memory; the fetched instruction is valid in the same cycle as `pc`.

Parameters:
- `ADDR_WIDTH`, 4: width of the program address, `pc`, `target` and `offset`; the address space is 2^ADDR_WIDTH words.
- `STACK_DEPTH`, 4: number of return-address entries; must be at least 1.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `en`  input  1  advance enable; 0 = stall, all state held.
- `branch`  input  1  take a relative branch this cycle; flag condition already resolved by the decoder.
- `jump`  input  1  absolute jump to `target`.
- `call`  input  1  push return address, then jump to `target`.
- `ret`  input  1  pop return address into `pc`.
- `target`  input  ADDR_WIDTH  absolute destination for `jump`/`call`.
- `offset`  input  ADDR_WIDTH  two's-complement relative displacement for `branch`.
- `pc`  output  ADDR_WIDTH  current fetch address, connected to the program memory address.
- `sp`  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- `fault`  output  1  sticky stack-error flag.

Behaviour:
- Reset (async assert, any time): `pc`=0, `sp`=0, `fault`=0. Stack contents are don't-care. Release is synchronous to `clk`; the first fetch is address 0.
- `pc` is a register. Program memory is combinational, so the instruction for `pc` is available in the same cycle: zero-cycle fetch latency, one-cycle redirect latency.
- Per rising edge with `en`=1 and `fault`=0, exactly one action is taken, chosen by fixed priority ret > call > jump > branch > increment:
  - ret: `pc` <- stack[sp-1]; `sp` <- sp-1.
  - call: stack[sp] <- pc+1 (mod 2^ADDR_WIDTH); `sp` <- sp+1; `pc` <- `target`.
  - jump: `pc` <- `target`.
  - branch: `pc` <- pc + sign-extended `offset`, mod 2^ADDR_WIDTH. The offset is relative to the branch instruction's own address.
  - none asserted: `pc` <- pc+1, wrapping from 2^ADDR_WIDTH-1 to 0.
- Lower-priority requests asserted in the same cycle as a higher one are ignored, with no side effects.
- `en`=0: `pc`, `sp`, stack and `fault` are held; control inputs are ignored.
- Overflow: `call` with `sp`=STACK_DEPTH sets `fault`=1. No push; `pc` and `sp` are unchanged.
- Underflow: `ret` with `sp`=0 sets `fault`=1. No pop; `pc` and `sp` are unchanged.
- While `fault`=1 the sequencer is halted: `pc` and `sp` are frozen regardless of `en` or control inputs. Only `reset` clears `fault`.
- Simultaneous `call`+`ret`: `ret` wins, including its underflow check. `call` is ignored.
- `sp` never exceeds STACK_DEPTH and never wraps.
- States: RUN (`fault`=0) and HALT (`fault`=1).
  - RUN -> HALT on overflow or underflow.
  - HALT -> RUN only via `reset`.

Test Plan:
- Reset, then `en`=1 with no controls for 17 cycles: `pc` = 0,1,…,15,0 (wrap), `sp`=0, `fault`=0 throughout.
- `pc`=5, `branch`=1, `offset`=4'hD (-3): next `pc`=2. `pc`=14, `offset`=4'h3: next `pc`=1 (wrap).
- `pc`=3, `call`=1, `target`=9: `pc`=9, `sp`=1. Two increments to `pc`=11, then `ret`=1: `pc`=4, `sp`=0.
- Five nested calls with STACK_DEPTH=4: after the 4th, `sp`=4. On the 5th, `fault`=1 and `pc`/`sp` are frozen for 10 further cycles with `en`=1 and random controls. Also `ret` at `sp`=0: `fault`=1, `pc` unchanged.
- `pc`=6, `en`=0 for 3 cycles with `jump`=1, `target`=2: `pc` stays 6. On `en`=1, `pc`=2. Same cycle with `ret`+`call`+`jump` at `sp`=1 holding 7: `pc`=7, `sp`=0.
- Assert `reset` mid-cycle between edges with `pc`=10, `sp`=2, `fault`=1: outputs go to 0/0/0 immediately, without waiting for a clock edge. After release, `pc` counts from 0.
